// File: rtl/conv_ctrl_pkg.sv
// Shared definitions for the convolution adder-tree sequencer.
// Holds datapath widths, adder latency, FIFO depth, the controller state
// encoding, the tag carried alongside each beat and a sign-extension helper.
package conv_ctrl_pkg;

  localparam int unsigned ADD_LAT    = 2;   // adder-tree latency in cycles
  localparam int unsigned FIFO_DEPTH = 4;   // completed-pixel FIFO depth
  localparam int unsigned ACC_W      = 32;  // accumulator / output width
  localparam int unsigned DIN_W      = 24;  // adder-tree result width
  localparam int unsigned PASS_W     = 6;   // pass counter width
  localparam int unsigned PIX_W      = 16;  // pixel counter width
  localparam int unsigned CREDIT_W   = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Travels with each accepted beat so it lines up with add_dout.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  function automatic logic signed [ACC_W-1:0] sext_din(input logic signed [DIN_W-1:0] d);
    return {{(ACC_W - DIN_W){d[DIN_W-1]}}, d};
  endfunction

endpackage

// File: rtl/conv_acc_fifo.sv
// Synchronous FIFO holding completed pixel sums.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i, wdata_i    write strobe and data (ignored when full)
//   pop_i              read strobe (ignored when empty)
//   rdata_o            head entry
//   full_o, empty_o    occupancy flags
// Depth must be a power of two.
module conv_acc_fifo
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned Depth = FIFO_DEPTH,
  parameter int unsigned Width = ACC_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q;
  logic [AddrW:0]   rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_add_seq_ctrl.sv
// Sequencer for a convolution adder tree. Walks a job of num_pix output
// pixels, each built from num_pass channel-pair beats, gates the bias on the
// first pass of each pixel, accumulates the delayed adder-tree results and
// queues each finished pixel sum for downstream.
// Ports:
//   sclk, s_rst_n               clock, asynchronous active-low reset
//   start, cfg_num_pass/pix     job start pulse and job shape (sampled on start)
//   in_valid / in_ready         upstream beat handshake
//   bias_enable                 bias gate to the adder tree
//   add_dout                    adder-tree result, ADD_LAT cycles after a beat
//   acc_out, acc_valid/ready    completed pixel sum stream
//   busy, done                  job status; done pulses for one cycle
module conv_add_seq_ctrl
  import conv_ctrl_pkg::*;
(
  input  logic                    sclk,
  input  logic                    s_rst_n,
  input  logic                    start,
  input  logic [PASS_W-1:0]       cfg_num_pass,
  input  logic [PIX_W-1:0]        cfg_num_pix,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    bias_enable,
  input  logic signed [DIN_W-1:0] add_dout,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    acc_valid,
  input  logic                    acc_ready,
  output logic                    busy,
  output logic                    done
);

  state_e                  state_q;
  logic [PASS_W-1:0]       num_pass_q;
  logic [PIX_W-1:0]        num_pix_q;
  logic [PASS_W-1:0]       pass_cnt_q;
  logic [PIX_W-1:0]        pix_cnt_q;
  logic [CREDIT_W-1:0]     credit_q;
  tag_t                    tag_q [ADD_LAT];
  logic signed [ACC_W-1:0] acc_q;

  logic                    last_pass;
  logic                    last_pix;
  logic                    accept;
  logic                    credit_dec;
  logic                    pop;
  logic                    pipe_empty;
  tag_t                    tag_in;
  tag_t                    tag_out;
  logic signed [ACC_W-1:0] add_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic                    push;
  logic [ACC_W-1:0]        fifo_rdata;
  logic                    fifo_empty;
  logic                    unused_fifo_full;

  assign last_pass   = (pass_cnt_q == num_pass_q - PASS_W'(1));
  assign last_pix    = (pix_cnt_q == num_pix_q - PIX_W'(1));
  // Last-pass beats are held back while no FIFO slot is reserved for them.
  assign in_ready    = (state_q == StRun) && ((credit_q != '0) || !last_pass);
  assign bias_enable = (state_q == StRun) && (pass_cnt_q == '0);
  assign accept      = in_valid && in_ready;
  assign credit_dec  = accept && last_pass;
  assign acc_valid   = !fifo_empty;
  assign pop         = acc_valid && acc_ready;
  assign acc_out     = fifo_rdata;
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);

  always_comb begin
    tag_in       = '0;
    tag_in.valid = accept;
    tag_in.first = accept && (pass_cnt_q == '0);
    tag_in.last  = credit_dec;
  end

  always_comb begin
    pipe_empty = 1'b1;
    for (int unsigned i = 0; i < ADD_LAT; i++) begin
      if (tag_q[i].valid) begin
        pipe_empty = 1'b0;
      end
    end
  end

  assign tag_out = tag_q[ADD_LAT-1];
  assign add_ext = sext_din(add_dout);
  assign acc_sum = tag_out.first ? add_ext : acc_q + add_ext;
  assign push    = tag_out.valid && tag_out.last;

  // Controller FSM, job counters and FIFO credits.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q    <= StIdle;
      num_pass_q <= PASS_W'(1);
      num_pix_q  <= '0;
      pass_cnt_q <= '0;
      pix_cnt_q  <= '0;
      credit_q   <= CREDIT_W'(FIFO_DEPTH);
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            num_pass_q <= (cfg_num_pass == '0) ? PASS_W'(1) : cfg_num_pass;
            num_pix_q  <= cfg_num_pix;
            pass_cnt_q <= '0;
            pix_cnt_q  <= '0;
            state_q    <= (cfg_num_pix == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (accept) begin
            if (last_pass) begin
              pass_cnt_q <= '0;
              if (last_pix) begin
                state_q <= StDrain;
              end else begin
                pix_cnt_q <= pix_cnt_q + PIX_W'(1);
              end
            end else begin
              pass_cnt_q <= pass_cnt_q + PASS_W'(1);
            end
          end
        end
        StDrain: begin
          if (pipe_empty && fifo_empty) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      case ({credit_dec, pop})
        2'b10:   credit_q <= credit_q - CREDIT_W'(1);
        2'b01:   credit_q <= credit_q + CREDIT_W'(1);
        default: credit_q <= credit_q;
      endcase
    end
  end

  // Tag pipe mirrors the adder-tree latency; it never stalls.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int unsigned i = 0; i < ADD_LAT; i++) begin
        tag_q[i] <= '0;
      end
      acc_q <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int unsigned i = 1; i < ADD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      if (tag_out.valid) begin
        acc_q <= acc_sum;
      end
    end
  end

  conv_acc_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(ACC_W)
  ) u_fifo (
    .clk_i  (sclk),
    .rst_ni (s_rst_n),
    .push_i (push),
    .wdata_i(acc_sum),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .full_o (unused_fifo_full),
    .empty_o(fifo_empty)
  );

endmodule

// File: tb/tb_conv_add_seq_ctrl.sv
// Directed self-checking bench for conv_add_seq_ctrl. A small adder-tree
// model returns beat data plus the gated bias two cycles after acceptance.
module tb_conv_add_seq_ctrl;

  logic               sclk = 1'b0;
  logic               s_rst_n = 1'b1;
  logic               start = 1'b0;
  logic [5:0]         cfg_num_pass = '0;
  logic [15:0]        cfg_num_pix = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               bias_enable;
  logic signed [23:0] add_dout;
  logic signed [31:0] acc_out;
  logic               acc_valid;
  logic               acc_ready = 1'b0;
  logic               busy;
  logic               done;

  conv_add_seq_ctrl dut (
    .sclk        (sclk),
    .s_rst_n     (s_rst_n),
    .start       (start),
    .cfg_num_pass(cfg_num_pass),
    .cfg_num_pix (cfg_num_pix),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .bias_enable (bias_enable),
    .add_dout    (add_dout),
    .acc_out     (acc_out),
    .acc_valid   (acc_valid),
    .acc_ready   (acc_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 sclk = ~sclk;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [23:0] beat_data = '0;
  logic signed [23:0] bias_val = '0;
  logic signed [23:0] nxt_val = '0;
  logic signed [23:0] add_p1;
  logic signed [23:0] beat_vals [16];
  int                 exp_out [16];
  logic               exp_bias [16];
  logic signed [31:0] out_rec [$];
  logic               bias_rec [$];
  int                 done_cnt = 0;
  bit                 av_seen = 1'b0;

  // Mid-cycle monitor and adder-tree model input.
  always @(negedge sclk) begin
    if (in_valid && in_ready) begin
      nxt_val = beat_data + (bias_enable ? bias_val : 24'sd0);
      bias_rec.push_back(bias_enable);
    end else begin
      nxt_val = '0;
    end
    if (acc_valid && acc_ready) out_rec.push_back(acc_out);
    if (done) done_cnt++;
    if (acc_valid) av_seen = 1'b1;
  end

  always @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      add_p1   <= '0;
      add_dout <= '0;
    end else begin
      add_p1   <= nxt_val;
      add_dout <= add_p1;
    end
  end

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  task automatic clear_rec;
    out_rec.delete();
    bias_rec.delete();
    done_cnt = 0;
    av_seen  = 1'b0;
  endtask

  task automatic do_start(input logic [5:0] p, input logic [15:0] x);
    start        = 1'b1;
    cfg_num_pass = p;
    cfg_num_pix  = x;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_beats(input int n);
    for (int i = 0; i < n; i++) begin
      bit acc;
      int cyc;
      in_valid  = 1'b1;
      beat_data = beat_vals[i];
      cyc = 0;
      acc = 1'b0;
      while (!acc && cyc < 200) begin
        @(negedge sclk);
        acc = in_ready;
        tick();
        cyc++;
      end
      if (!acc) begin
        n_cmp++;
        n_err++;
        $display("FAIL beat_timeout: beat %0d not accepted within %0d cycles", i, cyc);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 500) begin
      tick();
      cyc++;
    end
    tick();
    n_cmp++;
    if (done_cnt == 0) begin
      n_err++;
      $display("FAIL %s_done_timeout: done seen %0d times, required 1", name, done_cnt);
    end
  endtask

  task automatic check_outputs(input string name, input int n_out, input int n_bias);
    n_cmp++;
    if (out_rec.size() != n_out) begin
      n_err++;
      $display("FAIL %s_out_count: got %0d required %0d", name, out_rec.size(), n_out);
    end
    for (int i = 0; i < n_out && i < out_rec.size(); i++) begin
      n_cmp++;
      if (out_rec[i] !== exp_out[i]) begin
        n_err++;
        $display("FAIL %s_acc_out[%0d]: got %0d required %0d", name, i, out_rec[i], exp_out[i]);
      end
    end
    for (int i = 0; i < n_bias && i < bias_rec.size(); i++) begin
      n_cmp++;
      if (bias_rec[i] !== exp_bias[i]) begin
        n_err++;
        $display("FAIL %s_bias[%0d]: got %0b required %0b", name, i, bias_rec[i], exp_bias[i]);
      end
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_err++;
      $display("FAIL %s_done_pulses: got %0d required 1", name, done_cnt);
    end
    @(negedge sclk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle_busy: got %0b required 0", name, busy);
    end
    tick();
  endtask

  task automatic test_reset;
    logic [4:0] got;
    string nm [5] = '{"in_ready", "bias_enable", "acc_valid", "busy", "done"};
    #1 s_rst_n = 1'b0;
    repeat (2) @(posedge sclk);
    @(negedge sclk);
    got = {in_ready, bias_enable, acc_valid, busy, done};
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (got[4-i] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_%s: got %0b required 0", nm[i], got[4-i]);
      end
    end
    n_cmp++;
    if (acc_out !== 32'sd0) begin
      n_err++;
      $display("FAIL reset_acc_out: got %0d required 0", acc_out);
    end
    tick();
    s_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_pass;
    clear_rec();
    acc_ready = 1'b1;
    bias_val  = 24'sd100;
    beat_vals[0] = 5; beat_vals[1] = 7; beat_vals[2] = 9;
    exp_out[0] = 105; exp_out[1] = 107; exp_out[2] = 109;
    for (int i = 0; i < 3; i++) exp_bias[i] = 1'b1;
    do_start(6'd1, 16'd3);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_busy: got %0b required 1", busy);
    end
    drive_beats(3);
    wait_done("single");
    check_outputs("single", 3, 3);
  endtask

  task automatic test_multi_pass;
    clear_rec();
    acc_ready = 1'b1;
    bias_val  = 24'sd10;
    for (int i = 0; i < 6; i++) begin
      beat_vals[i] = 24'(i + 1);
      exp_bias[i]  = (i == 0 || i == 3);
    end
    exp_out[0] = 16; exp_out[1] = 25;
    do_start(6'd3, 16'd2);
    drive_beats(6);
    wait_done("multi");
    check_outputs("multi", 2, 6);
  endtask

  task automatic test_backpressure;
    int idx = 0;
    int cyc = 0;
    bit acc;
    clear_rec();
    acc_ready = 1'b0;
    bias_val  = '0;
    for (int i = 0; i < 8; i++) begin
      beat_vals[i] = 24'(i + 1);
      exp_out[i]   = i + 1;
    end
    do_start(6'd1, 16'd8);
    in_valid  = 1'b1;
    beat_data = beat_vals[0];
    for (int c = 0; c < 20; c++) begin
      @(negedge sclk);
      acc = in_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 8) beat_data = beat_vals[idx];
      end
    end
    n_cmp++;
    if (idx != 4) begin
      n_err++;
      $display("FAIL bp_accepted: got %0d required 4", idx);
    end
    @(negedge sclk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_in_ready: got %0b required 0", in_ready);
    end
    n_cmp++;
    if (acc_valid !== 1'b1 || acc_out !== 32'sd1) begin
      n_err++;
      $display("FAIL bp_head_hold: got valid %0b data %0d required valid 1 data 1",
               acc_valid, acc_out);
    end
    tick();
    acc_ready = 1'b1;
    while (idx < 8 && cyc < 200) begin
      @(negedge sclk);
      acc = in_ready;
      tick();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 8) beat_data = beat_vals[idx];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (idx != 8) begin
      n_err++;
      $display("FAIL bp_drain_accept: got %0d required 8", idx);
    end
    wait_done("bp");
    check_outputs("bp", 8, 0);
  endtask

  task automatic test_sign_ext;
    clear_rec();
    acc_ready = 1'b1;
    bias_val  = '0;
    beat_vals[0] = -24'sd8388608;
    beat_vals[1] = -24'sd8388608;
    exp_out[0]  = -16777216;
    exp_bias[0] = 1'b1;
    exp_bias[1] = 1'b0;
    do_start(6'd2, 16'd1);
    drive_beats(2);
    wait_done("sext");
    check_outputs("sext", 1, 2);
  endtask

  task automatic test_reset_mid_run;
    logic [4:0] got;
    clear_rec();
    acc_ready = 1'b0;
    bias_val  = '0;
    for (int i = 0; i < 5; i++) beat_vals[i] = 24'(i + 1);
    do_start(6'd2, 16'd10);
    drive_beats(5);
    repeat (3) tick();
    @(negedge sclk);
    n_cmp++;
    if (acc_valid !== 1'b1 || acc_out !== 32'sd3) begin
      n_err++;
      $display("FAIL rst_pre_state: got valid %0b data %0d required valid 1 data 3",
               acc_valid, acc_out);
    end
    #2 s_rst_n = 1'b0;
    #1;
    got = {in_ready, bias_enable, acc_valid, busy, done};
    n_cmp++;
    if (got !== 5'b0 || acc_out !== 32'sd0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got flags %05b data %0d required 00000 and 0",
               got, acc_out);
    end
    @(posedge sclk);
    #1;
    clear_rec();
    acc_ready = 1'b1;
    s_rst_n   = 1'b1;
    beat_vals[0] = 42;
    exp_out[0]   = 42;
    exp_bias[0]  = 1'b1;
    do_start(6'd1, 16'd1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_first_edge_start: busy got %0b required 1", busy);
    end
    drive_beats(1);
    wait_done("rst");
    check_outputs("rst", 1, 1);
  endtask

  task automatic test_start_ignored_and_zero;
    clear_rec();
    acc_ready = 1'b1;
    bias_val  = '0;
    beat_vals[0] = 3;
    // Pass count 0 acts as 1; the mid-run start would otherwise reshape the job.
    do_start(6'd0, 16'd2);
    drive_beats(1);
    do_start(6'd5, 16'd0);
    beat_vals[0] = 4;
    drive_beats(1);
    exp_out[0] = 3; exp_out[1] = 4;
    exp_bias[0] = 1'b1; exp_bias[1] = 1'b1;
    wait_done("ign");
    check_outputs("ign", 2, 2);

    clear_rec();
    do_start(6'd1, 16'd0);
    @(negedge sclk);
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL zero_done_latency: got %0b required 1", done);
    end
    wait_done("zero");
    repeat (3) tick();
    n_cmp++;
    if (done_cnt != 1) begin
      n_err++;
      $display("FAIL zero_done_pulses: got %0d required 1", done_cnt);
    end
    n_cmp++;
    if (av_seen !== 1'b0) begin
      n_err++;
      $display("FAIL zero_acc_valid: got %0b required 0", av_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_backpressure();
    test_sign_ext();
    test_reset_mid_run();
    test_start_ignored_and_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_add_seq_ctrl.md
CONV_ADD_SEQ_CTRL -- requirements
Module: conv_add_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: sclk, s_rst_n.
REQ-002 sclk  input  1  system clock; all state changes on its rising edge.
REQ-003 s_rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle job start pulse; ignored unless state is IDLE.
REQ-005 cfg_num_pass  input  6  channel-pair passes per output pixel (1..63); the value 0 SHALL be treated as 1; sampled on start.
REQ-006 cfg_num_pix  input  16  output pixels per job (1..65535); the value 0 SHALL complete the job immediately; sampled on start.
REQ-007 in_valid  input  1  upstream presents data0..data7 to the adder tree this cycle.
REQ-008 in_ready  output  1  beat accepted when in_valid and in_ready are both high.
REQ-009 bias_enable  output  1  bias gate to the adder tree.
REQ-010 add_dout  input  24 signed  adder-tree result; valid exactly 2 cycles after the accepted beat.
REQ-011 acc_out  output  32 signed  completed pixel sum, taken from the FIFO head.
REQ-012 acc_valid / acc_ready  output / input  1 each  downstream handshake; a pop occurs when both are high.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when the job completes.

Function
REQ-015 States SHALL be IDLE, RUN, DRAIN and DONE: IDLE->RUN on start (IDLE->DONE if cfg_num_pix=0); RUN->DRAIN on acceptance of the final beat; DRAIN->DONE when the tag pipe is empty and the FIFO is empty; DONE->IDLE after 1 cycle.
REQ-016 Beat order SHALL be pixel-major, pass-minor; pass_cnt SHALL increment per accepted beat, wrapping to 0 after num_pass-1, at which point pix_cnt increments.
REQ-017 bias_enable SHALL equal (state==RUN && pass_cnt==0), so the bias is added once per pixel.
REQ-018 A 2-stage tag pipe of {valid, first, last} SHALL be loaded on each accepted beat and SHALL align with add_dout; it advances every cycle with no stall.
REQ-019 At pipe output: if first, acc <= sign-extended add_dout; otherwise acc <= acc + sign-extended add_dout (32-bit, no saturation needed: 63 x 24-bit fits).
REQ-020 If last, the value that would be written to acc SHALL be pushed into a 4-entry FIFO the same cycle; when num_pass=1, first and last are both set.
REQ-021 A credit counter (reset value 4) SHALL decrement on each accepted last-pass beat and increment on each FIFO pop; a simultaneous decrement and increment SHALL leave it unchanged.
REQ-022 in_ready SHALL equal (state==RUN && (credit>0 || pass_cnt != num_pass-1)), so the FIFO can never overflow.
REQ-023 acc_valid SHALL equal FIFO not-empty; acc_out SHALL hold while acc_valid is high and acc_ready is low.
REQ-024 A start pulse in any state other than IDLE SHALL have no effect.

Reset
REQ-025 On reset assertion: state=IDLE; in_ready, bias_enable, acc_valid, busy and done = 0; acc_out=0; counters=0; credit=4; tag pipe and FIFO cleared; any job in progress is abandoned.
REQ-026 After reset deassertion, the block SHALL accept a new start on the first clock edge.

Structure
REQ-027 Package conv_ctrl_pkg SHALL hold ADD_LAT=2, FIFO_DEPTH=4, ACC_W=32, DIN_W=24, the pass/pix counter widths and the state encoding.
REQ-028 The FIFO SHALL be a sub-module conv_acc_fifo (synchronous, depth FIFO_DEPTH, with full/empty flags).

Verification
REQ-029 pass=1, pix=3, add_dout model = data sum + bias 100, beats 5, 7, 9 -> bias_enable high on all three; acc_out 105, 107, 109; done 1 cycle after drain.
REQ-030 pass=3, pix=2, bias 10, beats 1,2,3,4,5,6 -> bias_enable only on beats 1 and 4; acc_out 16, then 25.
REQ-031 pass=1, pix=8, acc_ready=0 -> exactly 4 beats accepted, then in_ready=0; raise acc_ready -> remaining 4 beats drain; 8 outputs in order.
REQ-032 pass=2, add_dout -8388608 on both beats, bias 0 -> acc_out -16777216 (sign extension correct).
REQ-033 Reset pulse mid-RUN after 5 beats -> all outputs at reset values; new job pass=1, pix=1 -> one correct output.
REQ-034 start asserted during RUN, and a job with cfg_num_pix=0 -> the start during RUN is ignored; the pix=0 job raises done with no acc_valid.
